// File: rtl/kfpga_config_loader_if.sv
// Bitstream source handshake between a FIFO/DMA (master) and the config loader (slave).
interface kfpga_config_loader_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (output word_data, word_valid, input word_ready);
  modport slave  (input word_data, word_valid, output word_ready);
endinterface

// File: rtl/kfpga_config_loader.sv
// kFPGA configuration chain sequencer: optional flush + marker probe of chain length,
// then LSB-first serial load of the bitstream; holds fabric reset until done.
module kfpga_config_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 4096,
  parameter int COUNT_WIDTH  = 16,
  parameter bit PROBE_ENABLE = 1'b1
) (
  input  logic                 config_clock,
  input  logic                 config_nreset,
  input  logic                 start,
  kfpga_config_loader_if.slave word_if,
  output logic                 chain_out,
  output logic                 chain_enable,
  input  logic                 chain_in,
  output logic                 core_nreset,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);
  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam logic [COUNT_WIDTH-1:0] LEN_C = COUNT_WIDTH'(CHAIN_LENGTH);
  localparam logic [BW-1:0]          WW_C  = BW'(WORD_WIDTH);

  typedef enum logic [2:0] {IDLE, FLUSH, PROBE, LOAD, DONE, ERROR} state_t;

  state_t                 r_state, w_state;
  logic [COUNT_WIDTH-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic [BW-1:0]          r_bits, w_bits;
  logic [WORD_WIDTH-1:0]  r_word, w_word;
  logic r_ready, w_ready, r_out, w_out, r_en, w_en;
  logic r_nrst, w_nrst, r_busy, w_busy, r_done, w_done, r_err, w_err;

  assign w_cnt_inc          = r_cnt + 1'b1;
  assign word_if.word_ready = r_ready;
  assign chain_out          = r_out;
  assign chain_enable       = r_en;
  assign core_nreset        = r_nrst;
  assign busy               = r_busy;
  assign done               = r_done;
  assign error              = r_err;

  always_ff @(posedge config_clock or negedge config_nreset) begin
    if (!config_nreset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_word  <= '0;
      r_ready <= 1'b0;
      r_out   <= 1'b0;
      r_en    <= 1'b0;
      r_nrst  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bits  <= w_bits;
      r_word  <= w_word;
      r_ready <= w_ready;
      r_out   <= w_out;
      r_en    <= w_en;
      r_nrst  <= w_nrst;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bits  = r_bits;
    w_word  = r_word;
    w_ready = r_ready;
    w_out   = r_out;
    w_en    = r_en;
    w_nrst  = r_nrst;
    w_busy  = r_busy;
    w_done  = r_done;
    w_err   = r_err;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          w_done = 1'b0;
          w_err  = 1'b0;
          w_busy = 1'b1;
          w_nrst = 1'b0;
          w_cnt  = '0;
          w_out  = 1'b0;
          if (PROBE_ENABLE) begin
            w_state = FLUSH;
            w_en    = 1'b1;
          end else begin
            w_state = LOAD;
            w_ready = 1'b1;
            w_en    = 1'b0;
          end
        end
      end
      FLUSH: begin
        w_cnt = w_cnt_inc;
        if (w_cnt_inc == LEN_C) begin
          w_state = PROBE;
          w_out   = 1'b1;
          w_cnt   = '0;
        end
      end
      PROBE: begin
        // While shifting, any marker before c reaches the chain length means a short chain;
        // once shifting stops at c==length, chain_in must show the marker.
        if (r_en && !(r_cnt != '0 && chain_in)) begin
          w_cnt = w_cnt_inc;
          w_out = 1'b0;
          if (w_cnt_inc == LEN_C) w_en = 1'b0;
        end else if (!r_en && chain_in) begin
          w_state = LOAD;
          w_ready = 1'b1;
          w_cnt   = '0;
        end else begin
          w_state = ERROR;
          w_en    = 1'b0;
          w_out   = 1'b0;
          w_busy  = 1'b0;
          w_err   = 1'b1;
        end
      end
      LOAD: begin
        if (r_ready) begin
          if (word_if.word_valid) begin
            w_word  = word_if.word_data >> 1;
            w_out   = word_if.word_data[0];
            w_bits  = WW_C;
            w_ready = 1'b0;
            w_en    = 1'b1;
          end
        end else if (r_en) begin
          w_cnt  = w_cnt_inc;
          w_bits = r_bits - 1'b1;
          w_out  = r_word[0];
          w_word = r_word >> 1;
          if (w_cnt_inc == LEN_C) begin
            w_state = DONE;
            w_en    = 1'b0;
            w_out   = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_nrst  = 1'b1;
          end else if (r_bits == BW'(1)) begin
            w_en    = 1'b0;
            w_out   = 1'b0;
            w_ready = 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end
endmodule
